// File: rtl/rv32i_types.sv
// Shared types for the data-memory path: arbiter state encoding and helpers.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } dmem_arb_state_t;

    // The cache port is word-addressed; byte position is carried by the masks.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Serialises store-buffer and load-RS requests onto the single data-cache port.
// Loads win by default; a saturating counter forces a store grant once too many
// loads have jumped ahead of a pending store.
module dmem_arbiter
    import rv32i_types::*;
#(
    parameter int ROB_DEPTH    = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 dmem_w_rqst,
    input  logic                 store_buffer_full,
    input  logic [3:0]           arbiter_store_buffer_wmask,
    input  logic [31:0]          arbiter_store_buffer_addr,
    input  logic [31:0]          arbiter_store_buffer_wdata,
    output logic                 store_buffer_pop,

    input  logic                 load_rqst,
    input  logic [31:0]          load_addr,
    input  logic [3:0]           load_rmask,
    input  logic [ROB_DEPTH-1:0] load_rob_idx,
    output logic                 load_ack,

    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_resp,

    output logic                 cdb_load_valid,
    output logic [ROB_DEPTH-1:0] cdb_load_rob_idx,
    output logic [31:0]          cdb_load_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    dmem_arb_state_t      state, state_next;
    logic [CNT_W-1:0]     starve_cnt;
    logic                 grant_load, grant_store;

    logic [31:0]          req_addr;
    logic [3:0]           req_rmask;
    logic [3:0]           req_wmask;
    logic [31:0]          req_wdata;
    logic [ROB_DEPTH-1:0] req_tag;

    // Address and write data come straight from the request registers so they
    // hold their last value while idle.
    assign dmem_addr  = req_addr;
    assign dmem_wdata = req_wdata;

    // Grant decision, next state and per-state cache strobes.
    always_comb begin
        state_next       = state;
        grant_load       = 1'b0;
        grant_store      = 1'b0;
        load_ack         = 1'b0;
        store_buffer_pop = 1'b0;
        dmem_rmask       = 4'b0000;
        dmem_wmask       = 4'b0000;
        unique case (state)
            IDLE: begin
                if (dmem_w_rqst &&
                    (!load_rqst || store_buffer_full || starve_cnt == STARVE_MAX)) begin
                    grant_store = 1'b1;
                    state_next  = STORE;
                end else if (load_rqst) begin
                    grant_load = 1'b1;
                    load_ack   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                dmem_rmask = req_rmask;
                if (dmem_resp) state_next = IDLE;
            end
            STORE: begin
                dmem_wmask = req_wmask;
                if (dmem_resp) begin
                    store_buffer_pop = 1'b1;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Count loads that overtook a waiting store; cleared once no store waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_store || !dmem_w_rqst)
                starve_cnt <= '0;
            else if (grant_load && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Capture the granted request so the cache sees it stable until completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr  <= '0;
            req_rmask <= '0;
            req_wmask <= '0;
            req_wdata <= '0;
            req_tag   <= '0;
        end else if (grant_load) begin
            req_addr  <= word_align(load_addr);
            req_rmask <= load_rmask;
            req_tag   <= load_rob_idx;
        end else if (grant_store) begin
            req_addr  <= word_align(arbiter_store_buffer_addr);
            req_wmask <= arbiter_store_buffer_wmask;
            req_wdata <= arbiter_store_buffer_wdata;
        end
    end

    // Broadcast a completed load on the CDB for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_load_valid   <= 1'b0;
            cdb_load_rob_idx <= '0;
            cdb_load_rdata   <= '0;
        end else begin
            cdb_load_valid <= (state == LOAD) && dmem_resp;
            if ((state == LOAD) && dmem_resp) begin
                cdb_load_rob_idx <= req_tag;
                cdb_load_rdata   <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: tests push expected grants, a cache model
// answers requests, and a monitor checks grants, pops and CDB broadcasts.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_w_rqst, store_buffer_full, store_buffer_pop;
    logic [3:0]  arbiter_store_buffer_wmask;
    logic [31:0] arbiter_store_buffer_addr, arbiter_store_buffer_wdata;
    logic        load_rqst, load_ack;
    logic [31:0] load_addr;
    logic [3:0]  load_rmask;
    logic [2:0]  load_rob_idx;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp;
    logic        cdb_load_valid;
    logic [2:0]  cdb_load_rob_idx;
    logic [31:0] cdb_load_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ROB_DEPTH(3), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .dmem_w_rqst(dmem_w_rqst), .store_buffer_full(store_buffer_full),
        .arbiter_store_buffer_wmask(arbiter_store_buffer_wmask),
        .arbiter_store_buffer_addr(arbiter_store_buffer_addr),
        .arbiter_store_buffer_wdata(arbiter_store_buffer_wdata),
        .store_buffer_pop(store_buffer_pop),
        .load_rqst(load_rqst), .load_addr(load_addr), .load_rmask(load_rmask),
        .load_rob_idx(load_rob_idx), .load_ack(load_ack),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .cdb_load_valid(cdb_load_valid), .cdb_load_rob_idx(cdb_load_rob_idx),
        .cdb_load_rdata(cdb_load_rdata)
    );

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [2:0]  tag;
        logic [31:0] rdata;
    } exp_t;

    exp_t gq[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   lat = 2;
    int   n_cdb = 0, n_cdb_exp = 0;
    int   n_pop = 0, n_pop_exp = 0;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h1000_0004) return 32'hDEAD_BEEF;
        return a ^ 32'hC0FF_EE00;
    endfunction

    task automatic push(input bit st, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] wd, input logic [2:0] t, input logic [31:0] rd);
        exp_t e;
        e.st = st; e.addr = a; e.mask = m; e.wdata = wd; e.tag = t; e.rdata = rd;
        gq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    // Cache model: answers any active request after lat cycles.
    initial begin : cache_model
        int cc;
        cc = 0;
        dmem_resp = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            dmem_resp = 1'b0;
            if (rst) cc = 0;
            else if (dmem_rmask != 4'b0 || dmem_wmask != 4'b0) begin
                cc++;
                if (cc >= lat) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = rdata_of(dmem_addr);
                    cc = 0;
                end
            end
        end
    end

    // Monitor: checks grant order/content, pop timing and CDB broadcasts.
    initial begin : monitor
        bit act, prev_act, prev_ack, pend_cdb, exp_pop, ok;
        prev_act = 0; prev_ack = 0; pend_cdb = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_act = 0; prev_ack = 0; pend_cdb = 0;
                continue;
            end
            act = (dmem_rmask != 4'b0) || (dmem_wmask != 4'b0);
            if (cdb_load_valid || pend_cdb) begin
                checks++;
                if (cdb_load_valid) n_cdb++;
                if (cdb_load_valid !== pend_cdb ||
                    (pend_cdb && (cdb_load_rob_idx !== cur.tag || cdb_load_rdata !== cur.rdata))) begin
                    errors++;
                    $display("FAIL cdb got v=%b tag=%0d data=%h want v=%b tag=%0d data=%h",
                             cdb_load_valid, cdb_load_rob_idx, cdb_load_rdata,
                             pend_cdb, cur.tag, cur.rdata);
                end
            end
            pend_cdb = dmem_resp && (dmem_rmask != 4'b0);
            exp_pop  = dmem_resp && (dmem_wmask != 4'b0);
            if (store_buffer_pop || exp_pop) begin
                checks++;
                if (store_buffer_pop) n_pop++;
                if (store_buffer_pop !== exp_pop) begin
                    errors++;
                    $display("FAIL pop got %b want %b", store_buffer_pop, exp_pop);
                end
            end
            if (act) begin
                if (!prev_act) begin
                    if (gq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL grant_unexpected got addr=%h want none", dmem_addr);
                        cur.st = (dmem_wmask != 4'b0); cur.addr = dmem_addr;
                        cur.mask = cur.st ? dmem_wmask : dmem_rmask; cur.wdata = dmem_wdata;
                        cur.tag = '0; cur.rdata = '0;
                    end else begin
                        cur = gq.pop_front();
                        checks++;
                        if (prev_ack !== !cur.st) begin
                            errors++;
                            $display("FAIL load_ack_prev got %b want %b", prev_ack, !cur.st);
                        end
                    end
                end
                checks++;
                ok = ((dmem_wmask != 4'b0) == cur.st) && (dmem_addr === cur.addr);
                if (cur.st) ok = ok && dmem_wmask === cur.mask && dmem_rmask === 4'b0 &&
                                 dmem_wdata === cur.wdata;
                else        ok = ok && dmem_rmask === cur.mask && dmem_wmask === 4'b0;
                if (!ok) begin
                    errors++;
                    $display("FAIL request got st=%b addr=%h rm=%b wm=%b wd=%h want st=%b addr=%h m=%b wd=%h",
                             dmem_wmask != 4'b0, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
                             cur.st, cur.addr, cur.mask, cur.wdata);
                end
            end
            prev_act = act && !dmem_resp;
            prev_ack = load_ack;
        end
    end

    task automatic load_drv(input logic [31:0] a, input logic [3:0] m, input logic [2:0] t);
        bit ok;
        load_addr = a; load_rmask = m; load_rob_idx = t; load_rqst = 1'b1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (load_ack) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        load_rqst = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL load_ack_timeout got none want ack for addr %h", a);
        end
    endtask

    task automatic store_drv(input logic [31:0] a, input logic [3:0] m,
                             input logic [31:0] wd, input bit full);
        bit ok;
        arbiter_store_buffer_addr = a; arbiter_store_buffer_wmask = m;
        arbiter_store_buffer_wdata = wd; store_buffer_full = full; dmem_w_rqst = 1'b1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (store_buffer_pop) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        dmem_w_rqst = 1'b0; store_buffer_full = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL pop_timeout got none want pop for addr %h", a);
        end
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        dmem_w_rqst = 0; store_buffer_full = 0; arbiter_store_buffer_wmask = 0;
        arbiter_store_buffer_addr = 0; arbiter_store_buffer_wdata = 0;
        load_rqst = 0; load_addr = 0; load_rmask = 0; load_rob_idx = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        chk("rst_addr",  dmem_addr, 32'h0);
        chk("rst_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_ctrl",  {29'h0, store_buffer_pop, load_ack, cdb_load_valid}, 32'h0);
        chk("rst_cdb",   {cdb_load_rob_idx, cdb_load_rdata[28:0]}, 32'h0);

        // Load only
        lat = 2;
        push(0, 32'h1000_0004, 4'b1100, 32'h0, 3'd5, 32'hDEAD_BEEF); n_cdb_exp++;
        load_drv(32'h1000_0006, 4'b1100, 3'd5);
        settle();

        // Store only
        push(1, 32'h2000_0000, 4'b1111, 32'h1234_5678, 3'd0, 32'h0); n_pop_exp++;
        store_drv(32'h2000_0000, 4'b1111, 32'h1234_5678, 0);
        settle();

        // Simultaneous, buffer not full: load first
        push(0, 32'h0000_0200, 4'b0001, 32'h0, 3'd1, 32'hC0FF_EC00); n_cdb_exp++;
        push(1, 32'h6000_0004, 4'b1000, 32'hAA00_0000, 3'd0, 32'h0); n_pop_exp++;
        fork
            load_drv(32'h0000_0200, 4'b0001, 3'd1);
            store_drv(32'h6000_0004, 4'b1000, 32'hAA00_0000, 0);
        join
        settle();

        // Simultaneous, buffer full: store first (address realigned)
        push(1, 32'h7000_000C, 4'b1111, 32'h0BAD_F00D, 3'd0, 32'h0); n_pop_exp++;
        push(0, 32'h0000_0300, 4'b0110, 32'h0, 3'd2, 32'hC0FF_ED00); n_cdb_exp++;
        fork
            load_drv(32'h0000_0300, 4'b0110, 3'd2);
            store_drv(32'h7000_000E, 4'b1111, 32'h0BAD_F00D, 1);
        join
        settle();

        // Starvation: four loads, then the store, then the last load
        lat = 1;
        push(0, 32'h0000_0100, 4'b1111, 32'h0, 3'd3, 32'hC0FF_EF00);
        push(0, 32'h0000_0104, 4'b1111, 32'h0, 3'd4, 32'hC0FF_EF04);
        push(0, 32'h0000_0108, 4'b1111, 32'h0, 3'd5, 32'hC0FF_EF08);
        push(0, 32'h0000_010C, 4'b1111, 32'h0, 3'd6, 32'hC0FF_EF0C);
        push(1, 32'h5000_0008, 4'b0011, 32'h0000_ABCD, 3'd0, 32'h0);
        push(0, 32'h0000_0110, 4'b1111, 32'h0, 3'd7, 32'hC0FF_EF10);
        n_cdb_exp += 5; n_pop_exp++;
        fork
            begin
                load_drv(32'h0000_0100, 4'b1111, 3'd3);
                load_drv(32'h0000_0104, 4'b1111, 3'd4);
                load_drv(32'h0000_0108, 4'b1111, 3'd5);
                load_drv(32'h0000_010C, 4'b1111, 3'd6);
                load_drv(32'h0000_0110, 4'b1111, 3'd7);
            end
            store_drv(32'h5000_0008, 4'b0011, 32'h0000_ABCD, 0);
        join
        settle();

        // Reset during an outstanding load: no broadcast, then normal operation
        lat = 10;
        push(0, 32'h0000_0400, 4'b0011, 32'h0, 3'd6, 32'h0);
        load_drv(32'h0000_0400, 4'b0011, 3'd6);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        chk("midrst_addr",  dmem_addr, 32'h0);
        chk("midrst_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
        chk("midrst_wdata", dmem_wdata, 32'h0);
        chk("midrst_cdb",   cdb_load_rdata, 32'h0);
        chk("midrst_valid", {31'h0, cdb_load_valid}, 32'h0);
        repeat (12) @(posedge clk);
        #1;
        lat = 2;
        push(0, 32'h0000_0404, 4'b1111, 32'h0, 3'd7, 32'hC0FF_EA04); n_cdb_exp++;
        load_drv(32'h0000_0404, 4'b1111, 3'd7);
        settle();

        chk("grants_left", gq.size(), 32'd0);
        chk("cdb_count",   n_cdb, n_cdb_exp);
        chk("pop_count",   n_pop, n_pop_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Sits directly downstream of the store buffer and the load reservation station.
- Serialises their requests onto the single data-cache port using a request/response FSM.
- On store completion it pops the store buffer; on load completion it returns the raw data word and ROB tag to the CDB.
- Loads are normally preferred; bounded starvation protection guarantees stores drain.

## Interface
Parameters:
- ROB_DEPTH, 3, log2 of ROB entries; width of load tag.
- STARVE_LIMIT, 4, consecutive load grants allowed while a store is pending.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- dmem_w_rqst  in  1  store buffer has a valid tail entry.
- store_buffer_full  in  1  store buffer full.
- arbiter_store_buffer_wmask  in  4  tail entry byte mask, already lane-aligned.
- arbiter_store_buffer_addr  in  32  tail entry address.
- arbiter_store_buffer_wdata  in  32  tail entry data, already lane-aligned.
- store_buffer_pop  out  1  one-cycle pulse; retires tail entry.
- load_rqst  in  1  load RS presents a request.
- load_addr  in  32  load address.
- load_rmask  in  4  byte read mask, lane-aligned.
- load_rob_idx  in  ROB_DEPTH  ROB tag of the load.
- load_ack  out  1  one-cycle pulse; load request accepted this cycle.
- dmem_addr  out  32  word-aligned cache address, {addr[31:2],2'b00}.
- dmem_rmask  out  4  cache read mask.
- dmem_wmask  out  4  cache write mask.
- dmem_wdata  out  32  cache write data.
- dmem_rdata  in  32  cache read data.
- dmem_resp  in  1  cache completion, one cycle.
- cdb_load_valid  out  1  load result broadcast.
- cdb_load_rob_idx  out  ROB_DEPTH  tag of the returning load.
- cdb_load_rdata  out  32  raw word; load RS extracts and extends.

## Operation
- FSM states: IDLE, LOAD, STORE.
- IDLE grant decision (combinational, same cycle):
  - Grant STORE when dmem_w_rqst && (!load_rqst || store_buffer_full || starve_cnt == STARVE_LIMIT).
  - Otherwise grant LOAD when load_rqst.
  - Otherwise stay IDLE.
- On any grant: latch addr, masks, wdata and tag into request registers.
- load_ack is asserted in the LOAD grant cycle only.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments on each LOAD grant while dmem_w_rqst is high.
  - Clears on a STORE grant, and whenever dmem_w_rqst is low in IDLE.
  - Saturates at STARVE_LIMIT.
- LOAD state:
  - dmem_rmask = latched rmask; dmem_wmask = 0.
  - On dmem_resp: register dmem_rdata and the tag onto the CDB for one cycle, then go to IDLE.
- STORE state:
  - dmem_wmask and dmem_wdata driven from latched values; dmem_rmask = 0.
  - On dmem_resp: store_buffer_pop = 1 (combinational, that cycle only), then go to IDLE.
- In IDLE, dmem_rmask and dmem_wmask are 0; dmem_addr and dmem_wdata hold their last values.
- No flush input. An accepted load always completes and broadcasts; the ROB discards stale tags.
- Reset values:
  - state = IDLE, starve_cnt = 0, all request registers 0.
  - store_buffer_pop = 0, load_ack = 0, cdb_load_valid = 0, tag = 0, rdata = 0.
  - All dmem outputs 0.
- Reset mid-transaction: the FSM returns to IDLE immediately. No pop and no CDB pulse are produced for the abandoned request; the cache is reset by the same rst.

## Timing
- Grant at cycle N; the dmem request is visible from N+1 and held stable until dmem_resp.
- dmem_resp at cycle M (M ≥ N+1):
  - Store: pop at M. The store buffer tail advances at M+1, so the same entry is never re-granted.
  - Load: cdb_load_valid at M+1 for exactly one cycle.
- FSM is in IDLE at M+1 and may grant again at M+1. Back-to-back throughput is one request per (cache latency + 1) cycles.
- dmem_resp seen in IDLE is ignored.
- A load and a store requested in the same cycle: exactly one grant. The other request is held by its source; no ack or pop is issued for it.

## Structure
- Add the enum dmem_arb_state_t {IDLE, LOAD, STORE} to package rv32i_types.
- Single module; no sub-module. The starvation counter stays inline.

## Test plan
- Load only: addr 0x1000_0006, rmask 4'b1100, tag 5; cache responds 2 cycles later with 0xDEAD_BEEF.
  - load_ack at N; dmem_addr 0x1000_0004 with rmask 1100 from N+1.
  - CDB valid at M+1 with tag 5, data 0xDEADBEEF.
- Store only: addr 0x2000_0000, wmask 4'b1111, wdata 0x1234_5678.
  - Request held until resp; pop high exactly on the resp cycle; no CDB activity.
- Simultaneous load and store, store_buffer_full = 0: load granted first, then store. With store_buffer_full = 1: store granted first.
- Continuous loads with dmem_w_rqst held high, STARVE_LIMIT = 4: four load grants, then the fifth grant is the store.
- Reset asserted during LOAD before resp: no CDB pulse, outputs return to 0, and the next request is processed normally.
